imm_ext_arbiter: RTL

- Shares one immediate-extension datapath (sign/zero/upper/branch-offset) between two requesters: decode-stage immediate path (port 0) and branch-target path (port 1).
- Round-robin arbitration, one registered result slot, valid/ready output handshake with backpressure.
- Sits between the decode stage and the ALU/branch-adder operand muxes.

---
 rtl/imm_ext_arbiter_if.sv | 39 +++
 rtl/imm_ext_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter_if.sv
// -----------------------------------------------------------------------------
// imm_ext_arbiter_if
// Handshake bundle between the two immediate requesters, the shared
// extension arbiter and the downstream operand consumer.
//   Req0/Imm0/Mode0/Gnt0 : decode-stage immediate requester (port 0)
//   Req1/Imm1/Mode1/Gnt1 : branch-target requester (port 1)
//   OutValid/OutReady    : result slot handshake toward the ALU/branch adder
//   OutData/OutId        : extended result and the index of its requester
// Modports:
//   slave  : the arbiter's view (requests in, grants/results out)
//   master : the environment's view (requests out, grants/results in)
// -----------------------------------------------------------------------------
interface imm_ext_arbiter_if #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
);
  logic             Req0;
  logic [IMM_W-1:0] Imm0;
  logic [1:0]       Mode0;
  logic             Gnt0;
  logic             Req1;
  logic [IMM_W-1:0] Imm1;
  logic [1:0]       Mode1;
  logic             Gnt1;
  logic             OutValid;
  logic             OutReady;
  logic [OUT_W-1:0] OutData;
  logic             OutId;

  modport slave (
    input  Req0, Imm0, Mode0, Req1, Imm1, Mode1, OutReady,
    output Gnt0, Gnt1, OutValid, OutData, OutId
  );

  modport master (
    output Req0, Imm0, Mode0, Req1, Imm1, Mode1, OutReady,
    input  Gnt0, Gnt1, OutValid, OutData, OutId
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// -----------------------------------------------------------------------------
// imm_ext_arbiter
// Shares one immediate-extension datapath between the decode-stage immediate
// path (port 0) and the branch-target path (port 1). Round-robin arbitration
// feeds a single registered result slot with a valid/ready output handshake.
// Ports:
//   Clk   : system clock, all state changes on the rising edge
//   Rst_n : synchronous active-low reset
//   bus   : imm_ext_arbiter_if.slave (requests, grants, result slot)
// Modes: 00 sign-extend, 01 zero-extend, 10 upper (imm << IMM_W),
//        11 branch offset (sign-extend then << 2).
// OUT_W is expected to be exactly 2*IMM_W.
// -----------------------------------------------------------------------------
module imm_ext_arbiter #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic                Clk,
  input  logic                Rst_n,
  imm_ext_arbiter_if.slave    bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             last_gnt_q, last_gnt_d;

  logic             accept_s;
  logic             gnt0_s, gnt1_s;
  logic [OUT_W-1:0] ext_s;

  // Extension datapath shared by both requesters.
  function automatic logic [OUT_W-1:0] ext_imm(
    input logic [IMM_W-1:0] imm,
    input logic [1:0]       mode
  );
    logic [OUT_W-1:0] sx;
    sx = {{IMM_W{imm[IMM_W-1]}}, imm};
    case (mode)
      2'b00:   ext_imm = sx;
      2'b01:   ext_imm = {{IMM_W{1'b0}}, imm};
      2'b10:   ext_imm = {imm, {IMM_W{1'b0}}};
      2'b11:   ext_imm = {sx[OUT_W-3:0], 2'b00};
      default: ext_imm = sx;
    endcase
  endfunction

  // Slot can take a new result when empty or when it drains this same cycle.
  assign accept_s = (state_q == ST_EMPTY) || bus.OutReady;

  // Round-robin grant: on contention the port that did not win last time wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!Rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (accept_s) begin
      if (bus.Req0 && bus.Req1) begin
        gnt0_s = last_gnt_q;
        gnt1_s = !last_gnt_q;
      end else if (bus.Req0) begin
        gnt0_s = 1'b1;
      end else if (bus.Req1) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Only the granted port's operands reach the extender, so an idle port's
  // X inputs never propagate into the slot.
  always_comb begin
    ext_s = {OUT_W{1'b0}};
    if (gnt1_s) begin
      ext_s = ext_imm(bus.Imm1, bus.Mode1);
    end else begin
      ext_s = ext_imm(bus.Imm0, bus.Mode0);
    end
  end

  // Next-state for the result slot and the round-robin pointer.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    id_d       = id_q;
    last_gnt_d = last_gnt_q;
    if (gnt0_s || gnt1_s) begin
      state_d    = ST_FULL;
      data_d     = ext_s;
      id_d       = gnt1_s;
      last_gnt_d = gnt1_s;
    end else if ((state_q == ST_FULL) && bus.OutReady) begin
      // Drain without refill: data/id keep their last value.
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset; pointer resets to 1 so port 0
  // wins the first contention.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= ST_EMPTY;
      data_q     <= {OUT_W{1'b0}};
      id_q       <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      id_q       <= id_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign bus.Gnt0     = gnt0_s;
  assign bus.Gnt1     = gnt1_s;
  assign bus.OutValid = (state_q == ST_FULL);
  assign bus.OutData  = data_q;
  assign bus.OutId    = id_q;

endmodule
